// File: rtl/wb_arbiter_4_masters.sv
// Four-master round-robin Wishbone arbiter sharing a single slave bus.
// Define ARB_TIMEOUT_EN to force-terminate cycles that the slave stalls for TIMEOUT_CYCLES strobes.
module wb_arbiter_4_masters #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned RESET_PTR      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [3:0]  i_m0_sel,
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [3:0]  i_m1_sel,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic        i_m2_cyc,
    input  logic        i_m2_stb,
    input  logic        i_m2_we,
    input  logic [3:0]  i_m2_sel,
    input  logic [31:0] i_m2_adr,
    input  logic [31:0] i_m2_dat,
    input  logic        i_m3_cyc,
    input  logic        i_m3_stb,
    input  logic        i_m3_we,
    input  logic [3:0]  i_m3_sel,
    input  logic [31:0] i_m3_adr,
    input  logic [31:0] i_m3_dat,
    output logic [31:0] o_m0_dat,
    output logic [31:0] o_m1_dat,
    output logic [31:0] o_m2_dat,
    output logic [31:0] o_m3_dat,
    output logic        o_m0_ack,
    output logic        o_m1_ack,
    output logic        o_m2_ack,
    output logic        o_m3_ack,
    output logic        o_m0_int,
    output logic        o_m1_int,
    output logic        o_m2_int,
    output logic        o_m3_int,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [3:0]  o_s_sel,
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    input  logic [31:0] i_s_dat,
    input  logic        i_s_ack,
    input  logic        i_s_int,
    output logic [1:0]  o_grant,
    output logic        o_busy,
    output logic        o_timeout
);

    localparam logic IDLE    = 1'b0;
    localparam logic GRANTED = 1'b1;

    localparam logic [1:0]  PTR_INIT = 2'(RESET_PTR);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    logic        state;
    logic        granted;
    logic [1:0]  ptr;
    logic [1:0]  grant;
    logic [1:0]  next_grant;
    logic        timeout_pulse;

    logic [3:0]  m_cyc;
    logic [3:0]  m_stb;
    logic [3:0]  m_we;
    logic [3:0]  m_ack;
    logic [3:0]  m_sel  [4];
    logic [31:0] m_adr  [4];
    logic [31:0] m_wdat [4];
    logic [31:0] m_rdat [4];

    assign m_cyc = {i_m3_cyc, i_m2_cyc, i_m1_cyc, i_m0_cyc};
    assign m_stb = {i_m3_stb, i_m2_stb, i_m1_stb, i_m0_stb};
    assign m_we  = {i_m3_we,  i_m2_we,  i_m1_we,  i_m0_we};

    assign m_sel[0]  = i_m0_sel;
    assign m_sel[1]  = i_m1_sel;
    assign m_sel[2]  = i_m2_sel;
    assign m_sel[3]  = i_m3_sel;
    assign m_adr[0]  = i_m0_adr;
    assign m_adr[1]  = i_m1_adr;
    assign m_adr[2]  = i_m2_adr;
    assign m_adr[3]  = i_m3_adr;
    assign m_wdat[0] = i_m0_dat;
    assign m_wdat[1] = i_m1_dat;
    assign m_wdat[2] = i_m2_dat;
    assign m_wdat[3] = i_m3_dat;

    assign granted = (state == GRANTED);

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        next_grant = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (m_cyc[ptr + 2'(k)]) begin
                next_grant = ptr + 2'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= PTR_INIT;
            grant <= 2'd0;
        end else if (state == IDLE) begin
            if (|m_cyc) begin
                grant <= next_grant;
                state <= GRANTED;
            end
        end else begin
            if (!m_cyc[grant]) begin
                state <= IDLE;
                ptr   <= grant + 2'd1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        stall;

    assign stall = granted && o_s_stb && !i_s_ack;

    // A pulse is only raised if the master is still holding cyc, so it always lands on a live grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt        <= 16'd0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            if (!granted || i_s_ack || !m_cyc[grant]) begin
                to_cnt <= 16'd0;
            end else if (stall) begin
                if (to_cnt == TO_LAST) begin
                    to_cnt        <= 16'd0;
                    timeout_pulse <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end
        end
    end
`else
    logic [15:0] unused_timeout_last;

    assign unused_timeout_last = TO_LAST;
    assign timeout_pulse       = 1'b0;
`endif

    // Slave bus and return path are pure muxes on the registered grant.
    always_comb begin
        o_s_cyc = 1'b0;
        o_s_stb = 1'b0;
        o_s_we  = 1'b0;
        o_s_sel = 4'd0;
        o_s_adr = 32'd0;
        o_s_dat = 32'd0;
        m_ack   = 4'd0;
        for (int k = 0; k < 4; k++) begin
            m_rdat[k] = 32'd0;
        end
        if (granted) begin
            o_s_cyc       = m_cyc[grant];
            o_s_stb       = m_stb[grant] & ~timeout_pulse;
            o_s_we        = m_we[grant];
            o_s_sel       = m_sel[grant];
            o_s_adr       = m_adr[grant];
            o_s_dat       = m_wdat[grant];
            m_ack[grant]  = i_s_ack | timeout_pulse;
            m_rdat[grant] = timeout_pulse ? 32'hDEADBEEF : i_s_dat;
        end
    end

    assign {o_m3_ack, o_m2_ack, o_m1_ack, o_m0_ack} = m_ack;
    assign o_m0_dat = m_rdat[0];
    assign o_m1_dat = m_rdat[1];
    assign o_m2_dat = m_rdat[2];
    assign o_m3_dat = m_rdat[3];

    assign o_m0_int = i_s_int;
    assign o_m1_int = i_s_int;
    assign o_m2_int = i_s_int;
    assign o_m3_int = i_s_int;

    assign o_grant   = grant;
    assign o_busy    = granted;
    assign o_timeout = timeout_pulse;

endmodule

// File: tb/tb_wb_arbiter_4_masters.sv
// Directed self-checking bench for wb_arbiter_4_masters.
// Build with ARB_TIMEOUT_EN to exercise the forced-termination path.
module tb_wb_arbiter_4_masters;

    logic        clk;
    logic        rst;
    logic [3:0]  m_cyc;
    logic [3:0]  m_stb;
    logic [3:0]  m_we;
    logic [3:0]  m_sel  [4];
    logic [31:0] m_adr  [4];
    logic [31:0] m_wdat [4];
    logic [31:0] m_rdat [4];
    logic [3:0]  m_ack;
    logic [3:0]  m_int;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic [31:0] s_rdat;
    logic        s_ack, s_int;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    wb_arbiter_4_masters #(.TIMEOUT_CYCLES(16), .RESET_PTR(0)) dut (
        .clk(clk), .rst(rst),
        .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]), .i_m0_sel(m_sel[0]),
        .i_m0_adr(m_adr[0]), .i_m0_dat(m_wdat[0]),
        .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]), .i_m1_sel(m_sel[1]),
        .i_m1_adr(m_adr[1]), .i_m1_dat(m_wdat[1]),
        .i_m2_cyc(m_cyc[2]), .i_m2_stb(m_stb[2]), .i_m2_we(m_we[2]), .i_m2_sel(m_sel[2]),
        .i_m2_adr(m_adr[2]), .i_m2_dat(m_wdat[2]),
        .i_m3_cyc(m_cyc[3]), .i_m3_stb(m_stb[3]), .i_m3_we(m_we[3]), .i_m3_sel(m_sel[3]),
        .i_m3_adr(m_adr[3]), .i_m3_dat(m_wdat[3]),
        .o_m0_dat(m_rdat[0]), .o_m1_dat(m_rdat[1]), .o_m2_dat(m_rdat[2]), .o_m3_dat(m_rdat[3]),
        .o_m0_ack(m_ack[0]), .o_m1_ack(m_ack[1]), .o_m2_ack(m_ack[2]), .o_m3_ack(m_ack[3]),
        .o_m0_int(m_int[0]), .o_m1_int(m_int[1]), .o_m2_int(m_int[2]), .o_m3_int(m_int[3]),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_sel(s_sel),
        .o_s_adr(s_adr), .o_s_dat(s_wdat),
        .i_s_dat(s_rdat), .i_s_ack(s_ack), .i_s_int(s_int),
        .o_grant(grant), .o_busy(busy), .o_timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc  = 4'd0;
        m_stb  = 4'd0;
        m_we   = 4'd0;
        s_rdat = 32'd0;
        s_ack  = 1'b0;
        s_int  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_sel[k]  = 4'hF;
            m_adr[k]  = 32'h1000 + 32'(k);
            m_wdat[k] = 32'hA000 + 32'(k);
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst   = 1'b0;
        m_cyc = 4'hF;
        m_stb = 4'hF;
        s_ack = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        checks++;
        if (s_cyc !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_cyc got %b expected 0", s_cyc); end
        checks++;
        if (grant !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant got %0d expected 0", grant); end
        checks++;
        if (m_ack !== 4'd0) begin errors++; $display("[TB] FAIL reset_ack got %b expected 0000", m_ack); end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b expected 0", timeout); end
        checks++;
        if (s_adr !== 32'd0) begin errors++; $display("[TB] FAIL reset_s_adr got %h expected 0", s_adr); end
        clear_inputs();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_m2();
        do_reset();
        m_cyc[2] = 1'b1;
        m_stb[2] = 1'b1;
        m_adr[2] = 32'h0000_0100;
        #1;
        checks++;
        if (s_cyc !== 1'b0) begin errors++; $display("[TB] FAIL m2_latency got %b expected 0", s_cyc); end
        step();
        checks++;
        if (s_cyc !== 1'b1) begin errors++; $display("[TB] FAIL m2_s_cyc got %b expected 1", s_cyc); end
        checks++;
        if (grant !== 2'd2) begin errors++; $display("[TB] FAIL m2_grant got %0d expected 2", grant); end
        checks++;
        if (s_adr !== 32'h0000_0100) begin errors++; $display("[TB] FAIL m2_s_adr got %h expected 00000100", s_adr); end
        s_ack  = 1'b1;
        s_rdat = 32'h1234_5678;
        #1;
        checks++;
        if (m_rdat[2] !== 32'h1234_5678) begin errors++; $display("[TB] FAIL m2_rdata got %h expected 12345678", m_rdat[2]); end
        checks++;
        if (m_ack !== 4'b0100) begin errors++; $display("[TB] FAIL m2_ack got %b expected 0100", m_ack); end
        checks++;
        if (m_rdat[0] !== 32'd0) begin errors++; $display("[TB] FAIL m0_rdata_isolated got %h expected 0", m_rdat[0]); end
        step();
        s_ack    = 1'b0;
        m_cyc[2] = 1'b0;
        m_stb[2] = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL m2_release got %b expected 0", busy); end
        // ptr is now 3, so m3 beats m0
        m_cyc[0] = 1'b1;
        m_cyc[3] = 1'b1;
        step();
        checks++;
        if (grant !== 2'd3) begin errors++; $display("[TB] FAIL ptr_after_m2 got %0d expected 3", grant); end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        do_reset();
        m_cyc = 4'hF;
        m_stb = 4'hF;
        step();
        for (int i = 0; i < 5; i++) begin
            g = 2'(i % 4);
            checks++;
            if (busy !== 1'b1 || grant !== g) begin
                errors++;
                $display("[TB] FAIL rr_grant_%0d got busy=%b grant=%0d expected busy=1 grant=%0d", i, busy, grant, g);
            end
            s_ack = 1'b1;
            #1;
            checks++;
            if (m_ack !== (4'b0001 << g)) begin
                errors++;
                $display("[TB] FAIL rr_ack_%0d got %b expected %b", i, m_ack, 4'b0001 << g);
            end
            step();
            s_ack    = 1'b0;
            m_cyc[g] = 1'b0;
            step();
            checks++;
            if (busy !== 1'b0 || s_cyc !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rr_gap_%0d got busy=%b s_cyc=%b expected 0 0", i, busy, s_cyc);
            end
            m_cyc[g] = 1'b1;
            step();
        end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_burst();
        do_reset();
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        step();
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        for (int b = 0; b < 8; b++) begin
            m_stb[1] = 1'b1;
            s_ack    = 1'b1;
            s_rdat   = 32'hB000 + 32'(b);
            #1;
            checks++;
            if (grant !== 2'd1 || m_ack !== 4'b0010 || m_rdat[1] !== 32'hB000 + 32'(b)) begin
                errors++;
                $display("[TB] FAIL burst_beat_%0d got grant=%0d ack=%b data=%h expected 1 0010 %h",
                         b, grant, m_ack, m_rdat[1], 32'hB000 + 32'(b));
            end
            step();
            if (b % 3 == 1) begin
                s_ack    = 1'b0;
                m_stb[1] = 1'b0;
                step();
            end
        end
        s_ack    = 1'b0;
        m_stb[1] = 1'b0;
        m_cyc[1] = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL burst_gap got %b expected 0", busy); end
        step();
        checks++;
        if (busy !== 1'b1 || grant !== 2'd0) begin
            errors++;
            $display("[TB] FAIL burst_next got busy=%b grant=%0d expected 1 0", busy, grant);
        end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_cyc[3] = 1'b1;
        m_stb[3] = 1'b1;
        m_we[3]  = 1'b1;
        step();
        checks++;
        if (grant !== 2'd3 || s_we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_grant got grant=%0d we=%b expected 3 1", grant, s_we);
        end
        #1;
        rst      = 1'b0;
        s_ack    = 1'b1;
        m_cyc[1] = 1'b1;
        #1;
        checks++;
        if (s_cyc !== 1'b0 || busy !== 1'b0 || m_ack !== 4'd0) begin
            errors++;
            $display("[TB] FAIL mid_abort got s_cyc=%b busy=%b ack=%b expected 0 0 0000", s_cyc, busy, m_ack);
        end
        step();
        s_ack = 1'b0;
        rst   = 1'b1;
        step();
        checks++;
        if (grant !== 2'd1) begin errors++; $display("[TB] FAIL mid_resume got %0d expected 1", grant); end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_interrupt();
        do_reset();
        m_cyc[2] = 1'b1;
        step();
        s_int = 1'b1;
        #1;
        checks++;
        if (m_int !== 4'hF) begin errors++; $display("[TB] FAIL int_high got %b expected 1111", m_int); end
        s_int = 1'b0;
        #1;
        checks++;
        if (m_int !== 4'h0) begin errors++; $display("[TB] FAIL int_low got %b expected 0000", m_int); end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        step();
`ifdef ARB_TIMEOUT_EN
        for (int n = 1; n <= 16; n++) begin
            checks++;
            if (m_ack !== 4'd0 || timeout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL to_early_%0d got ack=%b timeout=%b expected 0000 0", n, m_ack, timeout);
            end
            step();
        end
        checks++;
        if (m_ack !== 4'b0001 || m_rdat[0] !== 32'hDEADBEEF || timeout !== 1'b1 || s_stb !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_fire got ack=%b data=%h timeout=%b stb=%b expected 0001 deadbeef 1 0",
                     m_ack, m_rdat[0], timeout, s_stb);
        end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        step();
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse_end got %b expected 0", timeout); end
`else
        begin
            logic seen_ack;
            seen_ack = 1'b0;
            for (int n = 0; n < 1000; n++) begin
                if (m_ack !== 4'd0 || timeout !== 1'b0) seen_ack = 1'b1;
                step();
            end
            checks++;
            if (seen_ack !== 1'b0 || busy !== 1'b1 || grant !== 2'd0) begin
                errors++;
                $display("[TB] FAIL stall_hold got ack_seen=%b busy=%b grant=%0d expected 0 1 0", seen_ack, busy, grant);
            end
        end
`endif
        clear_inputs();
        step();
        step();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        step();
        test_reset();
        test_single_m2();
        test_round_robin();
        test_burst();
        test_reset_mid();
        test_interrupt();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_4_masters.md
WB_ARBITER_4_MASTERS -- requirements
Module: wb_arbiter_4_masters

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the number of stalled strobe cycles before a forced termination (16-bit, at least 2).
REQ-002 SHALL have parameter RESET_PTR, default 0, meaning the round-robin pointer value after reset (0..3).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports i_m{0..3}_cyc, i_m{0..3}_stb and i_m{0..3}_we, input, 1 bit each: Wishbone master cycle, strobe and write enable.
REQ-006 SHALL have ports i_m{0..3}_sel, input, 4 bits each: master byte selects.
REQ-007 SHALL have ports i_m{0..3}_adr and i_m{0..3}_dat, input, 32 bits each: master address and write data.
REQ-008 SHALL have ports o_m{0..3}_dat, output, 32 bits each: read data returned to each master.
REQ-009 SHALL have ports o_m{0..3}_ack and o_m{0..3}_int, output, 1 bit each: per-master acknowledge and interrupt.
REQ-010 SHALL have ports o_s_cyc, o_s_stb, o_s_we (1 bit), o_s_sel (4 bits), o_s_adr and o_s_dat (32 bits), output: the shared slave bus.
REQ-011 SHALL have ports i_s_dat (32 bits), i_s_ack and i_s_int (1 bit), input: slave read data, acknowledge and interrupt.
REQ-012 SHALL have port o_grant, output, 2 bits: index of the granted master.
REQ-013 SHALL have port o_busy, output, 1 bit: a grant is active.
REQ-014 SHALL have port o_timeout, output, 1 bit: one-cycle pulse on a forced termination.

Function
REQ-015 SHALL implement a two-state FSM with states IDLE and GRANTED.
REQ-016 In IDLE, when any i_mN_cyc is sampled high, SHALL register a grant on the next edge to the first requester in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4), then enter GRANTED.
REQ-017 Slave-side latency SHALL be exactly one clock from the first cyc sample in IDLE to o_s_cyc high.
REQ-018 In GRANTED, o_s_* SHALL combinationally follow the granted master's inputs, and o_busy SHALL be 1.
REQ-019 In GRANTED, i_s_dat and i_s_ack SHALL route only to the granted master; all other o_mN_ack and o_mN_dat SHALL be 0.
REQ-020 The grant SHALL be held for the whole of the granted master's cyc, including multi-beat bursts; stb gaps SHALL NOT release it.
REQ-021 When the granted master's cyc is sampled low, SHALL return to IDLE and set ptr to grant+1 (2-bit wrap, 3 -> 0).
REQ-022 On leaving GRANTED there SHALL be one cycle with o_s_cyc=0 before the next grant drives the slave bus.
REQ-023 Simultaneous requests SHALL resolve by pointer order only; no master SHALL wait more than 3 grants.
REQ-024 A request whose cyc drops before it is granted SHALL be dropped with no ack.
REQ-025 In IDLE, all o_s_* SHALL be 0.
REQ-026 i_s_int SHALL be broadcast to all four o_mN_int regardless of grant.

Reset
REQ-027 While rst=0: state=IDLE, ptr=RESET_PTR, o_grant=0, o_busy=0, o_timeout=0, timeout counter=0, and all o_s_* and o_mN_ack/dat = 0.
REQ-028 Assertion mid-transfer SHALL abort immediately, with no ack to any master.
REQ-029 After deassertion, arbitration SHALL resume from RESET_PTR.

Configuration
REQ-030 With macro ARB_TIMEOUT_EN defined: a 16-bit counter SHALL increment on each GRANTED cycle with o_s_stb=1 and i_s_ack=0, and SHALL clear on an ack or on leaving GRANTED.
REQ-031 With ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1, the next cycle SHALL drive o_mN_ack=1 to the granted master, o_mN_dat=32'hDEADBEEF, o_timeout=1, and o_s_stb=0 for that cycle; the counter SHALL then clear.
REQ-032 Without ARB_TIMEOUT_EN: no counter, o_timeout tied 0, and a stalled slave SHALL hold the grant indefinitely.

Verification
REQ-033 m2 requests alone after reset: o_s_cyc rises 1 clk after i_m2_cyc; o_grant=2; a slave read of 32'h12345678 appears on o_m2_dat with o_m2_ack; ptr becomes 3.
REQ-034 All four masters request continuously from reset with RESET_PTR=0: grants occur in order 0,1,2,3,0, each separated by one idle cycle.
REQ-035 m1 runs an 8-beat burst while m0 requests: m1 keeps o_grant=1 for all 8 acks; m0 is granted 2 clks after i_m1_cyc falls.
REQ-036 rst=0 mid-write by m3: o_s_cyc=0 and o_busy=0 asynchronously, no o_m3_ack; the first grant after release follows RESET_PTR.
REQ-037 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks: o_m0_ack=1 with 32'hDEADBEEF and o_timeout=1 on the 17th stalled cycle; without the macro, no ack after 1000 cycles.
REQ-038 i_s_int pulses while m2 is granted: o_m0_int..o_m3_int all =1 in the same cycle.
